// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and entry type shared by the fetch queue and decode
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int FQ_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of fetched (pc, instr) pairs between fetch and decode, flushed on redirect
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_instr,
  output logic             enq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_instr,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count
);
  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic enq, deq;
  // ready comes from count alone, so a full queue never accepts even while draining
  assign enq_ready = count != (PTR_W+1)'(DEPTH);
  assign deq_valid = count != '0;
  assign enq = enq_valid & enq_ready & ~flush;
  assign deq = deq_valid & deq_ready & ~flush;
  assign deq_pc = deq_valid ? mem[rd_ptr].pc : '0;
  assign deq_instr = deq_valid ? mem[rd_ptr].instr : NOP;
  always_ff @(posedge clock)
    if (enq) mem[wr_ptr] <= '{pc: enq_pc, instr: enq_instr};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= deq ? rd_ptr + PTR_W'(1) : rd_ptr;
      wr_ptr <= enq ? wr_ptr + PTR_W'(1) : wr_ptr;
      count  <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
endmodule
